// File: rtl/eda_visited_map_if.sv
`default_nettype none
// ============================================================================
// Module   : eda_visited_map_if
// Brief    : Clear, write, query and response bundle for eda_visited_map.
// Revision : 1.0
// ============================================================================
interface eda_visited_map_if #(
    parameter int NUM_NBR    = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                            clear_req;
    logic                            clear_busy;
    logic                            clear_done;
    logic                            new_pixel;
    logic [ADDR_WIDTH-1:0]           center_addr;
    logic [NUM_NBR*ADDR_WIDTH-1:0]   nbr_addr;
    logic [NUM_NBR-1:0]              push_positions;
    logic                            query_valid;
    logic                            query_ready;
    logic                            rsp_valid;
    logic [NUM_NBR:0]                rsp_flags;
    logic [ADDR_WIDTH:0]             visited_count;

    modport master (
        output clear_req, new_pixel, center_addr, nbr_addr, push_positions, query_valid,
        input  clear_busy, clear_done, query_ready, rsp_valid, rsp_flags, visited_count
    );

    modport slave (
        input  clear_req, new_pixel, center_addr, nbr_addr, push_positions, query_valid,
        output clear_busy, clear_done, query_ready, rsp_valid, rsp_flags, visited_count
    );
endinterface
`default_nettype wire

// File: rtl/eda_visited_map.sv
`default_nettype none
// ============================================================================
// Module   : eda_visited_map
// Brief    : M x N visited-flag map with write-through queries and row-sweep clear.
// Revision : 1.0
// ============================================================================
module eda_visited_map #(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int NUM_NBR    = 8,
    parameter int I_WIDTH    = $clog2(M),
    parameter int J_WIDTH    = $clog2(N),
    parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
    input wire               clk,
    input wire               reset,
    eda_visited_map_if.slave bus
);
    localparam int c_CELLS = M * N;
    localparam int c_IDX_W = $clog2(c_CELLS);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    localparam logic [I_WIDTH-1:0] c_ROW_LAST = I_WIDTH'(M - 1);

    // The row field is every bit above the column field, so a widened address can carry i >= M.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a[ADDR_WIDTH-1:J_WIDTH]) < M) && (32'(a[J_WIDTH-1:0]) < N);
    endfunction

    function automatic logic [c_IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return c_IDX_W'(32'(a[ADDR_WIDTH-1:J_WIDTH]) * N + 32'(a[J_WIDTH-1:0]));
    endfunction

    logic [0:0]            r_state;
    logic [I_WIDTH-1:0]    r_row;
    logic [c_CELLS-1:0]    r_map;
    logic                  r_done;
    logic                  r_rsp_valid;
    logic [NUM_NBR:0]      r_rsp_flags;
    logic [ADDR_WIDTH:0]   r_count;

    logic [ADDR_WIDTH-1:0] w_lane [NUM_NBR];
    logic [c_CELLS-1:0]    w_wmask;
    logic [c_CELLS-1:0]    w_new;
    logic [NUM_NBR:0]      w_flags;
    logic [ADDR_WIDTH:0]   w_add;

    generate
        for (genvar k = 0; k < NUM_NBR; k++) begin : g_lane
            assign w_lane[k] = bus.nbr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // All same-cycle writes collapse into one mask, which gives OR semantics for duplicates.
    always_comb begin
        w_wmask = '0;
        if (r_state == c_IDLE) begin
            if (bus.new_pixel && addr_ok(bus.center_addr)) begin
                w_wmask[addr_idx(bus.center_addr)] = 1'b1;
            end
            for (int k = 0; k < NUM_NBR; k++) begin
                if (bus.push_positions[k] && addr_ok(w_lane[k])) begin
                    w_wmask[addr_idx(w_lane[k])] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_flags = '1;
        for (int k = 0; k < NUM_NBR; k++) begin
            if (addr_ok(w_lane[k])) begin
                w_flags[k] = r_map[addr_idx(w_lane[k])] | w_wmask[addr_idx(w_lane[k])];
            end
        end
        if (addr_ok(bus.center_addr)) begin
            w_flags[NUM_NBR] = r_map[addr_idx(bus.center_addr)] | w_wmask[addr_idx(bus.center_addr)];
        end
    end

    // Only flags going 0 -> 1 count, so the total can never exceed M*N.
    always_comb begin
        w_new = w_wmask & ~r_map;
        w_add = '0;
        for (int b = 0; b < c_CELLS; b++) begin
            w_add = w_add + (ADDR_WIDTH+1)'(w_new[b]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_row       <= '0;
            r_map       <= '0;
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_flags <= '0;
            r_count     <= '0;
        end else begin
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
            if (r_state == c_IDLE) begin
                r_map   <= r_map | w_wmask;
                r_count <= r_count + w_add;
                if (bus.query_valid) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_flags <= w_flags;
                end
                if (bus.clear_req) begin
                    r_state <= c_CLEAR;
                    r_row   <= '0;
                    r_count <= '0;
                end
            end else begin
                for (int r = 0; r < M; r++) begin
                    if (r_row == I_WIDTH'(r)) begin
                        r_map[r*N +: N] <= '0;
                    end
                end
                r_row <= r_row + 1'b1;
                if (r_row == c_ROW_LAST) begin
                    r_state <= c_IDLE;
                    r_row   <= '0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.clear_busy    = (r_state == c_CLEAR);
    assign bus.query_ready   = (r_state == c_IDLE);
    assign bus.clear_done    = r_done;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_flags     = r_rsp_flags;
    assign bus.visited_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_eda_visited_map.sv
`default_nettype none
// ============================================================================
// Module   : tb_eda_visited_map
// Brief    : Scoreboard bench for eda_visited_map against a flag-array model.
// Revision : 1.0
// ============================================================================
module tb_eda_visited_map;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int NB = 8;
    localparam int IW = 3;
    localparam int JW = 2;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    eda_visited_map_if #(.NUM_NBR(NB), .ADDR_WIDTH(AW)) bus ();

    eda_visited_map #(
        .M(M), .N(N), .NUM_NBR(NB), .I_WIDTH(IW), .J_WIDTH(JW), .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [NB:0] flags;
        logic [AW:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mdl [M][N];
    int   mcount   = 0;
    int   mleft    = 0;
    bit   exp_done = 1'b0;
    int   total    = 0;
    int   bad      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [AW-1:0] a);
        return ((int'(a) / (1 << JW)) < M) && ((int'(a) % (1 << JW)) < N);
    endfunction

    function automatic int row_of(input logic [AW-1:0] a);
        return int'(a) / (1 << JW);
    endfunction

    function automatic int col_of(input logic [AW-1:0] a);
        return int'(a) % (1 << JW);
    endfunction

    function automatic logic [NB*AW-1:0] lanes_seq(input int base);
        logic [NB*AW-1:0] v = '0;
        for (int k = 0; k < NB; k++) v[k*AW +: AW] = AW'(base + k);
        return v;
    endfunction

    // One clock of stimulus; the model decides what the map should look like afterwards.
    task automatic step(input bit np, input logic [AW-1:0] ca, input logic [NB*AW-1:0] nb,
                        input logic [NB-1:0] push, input bit qv, input bit creq);
        bit w [M][N];
        exp_t e;
        logic [AW-1:0] a;
        bus.new_pixel      = np;
        bus.center_addr    = ca;
        bus.nbr_addr       = nb;
        bus.push_positions = push;
        bus.query_valid    = qv;
        bus.clear_req      = creq;
        exp_done = 1'b0;
        if (mleft == 0) begin
            if (np && in_rng(ca)) w[row_of(ca)][col_of(ca)] = 1'b1;
            for (int k = 0; k < NB; k++) begin
                a = nb[k*AW +: AW];
                if (push[k] && in_rng(a)) w[row_of(a)][col_of(a)] = 1'b1;
            end
            if (qv) begin
                for (int k = 0; k < NB; k++) begin
                    a = nb[k*AW +: AW];
                    e.flags[k] = in_rng(a) ? (mdl[row_of(a)][col_of(a)] | w[row_of(a)][col_of(a)]) : 1'b1;
                end
                e.flags[NB] = in_rng(ca) ? (mdl[row_of(ca)][col_of(ca)] | w[row_of(ca)][col_of(ca)]) : 1'b1;
            end
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    if (w[i][j] && !mdl[i][j]) begin
                        mdl[i][j] = 1'b1;
                        mcount++;
                    end
            if (creq) begin
                mcount = 0;
                foreach (mdl[i, j]) mdl[i][j] = 1'b0;
                mleft = M;
            end
            if (qv) begin
                e.cnt = AW'(0) + (AW+1)'(mcount);
                sb.push_back(e);
            end
        end else begin
            mleft--;
            if (mleft == 0) exp_done = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("clear_busy", 32'(bus.clear_busy), 32'(mleft > 0));
        chk("query_ready", 32'(bus.query_ready), 32'(mleft == 0));
        chk("clear_done", 32'(bus.clear_done), 32'(exp_done));
        chk("visited_count", 32'(bus.visited_count), 32'(mcount));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.clear_busy), 0);
        chk("rst_done", 32'(bus.clear_done), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_flags", 32'(bus.rsp_flags), 0);
        chk("rst_count", 32'(bus.visited_count), 0);
        chk("rst_ready", 32'(bus.query_ready), 1);
        foreach (mdl[i, j]) mdl[i][j] = 1'b0;
        mcount = 0;
        mleft  = 0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_done_hold", 32'(bus.clear_done), 0);
        reset = 1'b0;
    endtask

    task automatic query_all();
        step(0, AW'(16), lanes_seq(0), '0, 1, 0);
        step(0, AW'(16), lanes_seq(8), '0, 1, 0);
    endtask

    task automatic fill_map();
        step(1, AW'(0), lanes_seq(1), 8'hFF, 0, 0);
        step(1, AW'(9), lanes_seq(10), 8'hFF, 0, 0);
        chk("full_count", 32'(bus.visited_count), 16);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 flags=%0h expected no response", bus.rsp_flags);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_flags", 32'(bus.rsp_flags), 32'(mon_e.flags));
                chk("rsp_count", 32'(bus.visited_count), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB*AW-1:0] nb;
        bus.new_pixel      = 1'b0;
        bus.center_addr    = '0;
        bus.nbr_addr       = '0;
        bus.push_positions = '0;
        bus.query_valid    = 1'b0;
        bus.clear_req      = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single write then query of {1,2}
        step(1, AW'(6), '0, '0, 0, 0);
        step(0, AW'(6), '0, '0, 1, 0);
        chk("cnt_single", 32'(bus.visited_count), 1);

        // Duplicate writes to one address count once
        nb = '0; nb[0*AW +: AW] = AW'(5); nb[1*AW +: AW] = AW'(5);
        step(1, AW'(5), nb, 8'h03, 0, 0);
        chk("cnt_dup", 32'(bus.visited_count), 2);
        step(0, AW'(5), '0, '0, 1, 0);

        // Write-through: query sees a write made in the same cycle
        nb = '0; nb[3*AW +: AW] = AW'(9);
        step(1, AW'(9), nb, '0, 1, 0);

        // Out-of-range row reads 1 and is never counted
        nb = '0; nb[2*AW +: AW] = AW'(21);
        step(0, AW'(0), nb, 8'h04, 1, 0);
        chk("cnt_oor", 32'(bus.visited_count), 3);

        // Full map, saturation, then a clear sweep with queries and writes blocked
        fill_map();
        step(1, AW'(0), lanes_seq(0), 8'hFF, 0, 0);
        step(0, AW'(0), '0, '0, 1, 1);
        for (int c = 0; c < M; c++) step(1, AW'(c), lanes_seq(c), 8'hFF, 1, 1);
        query_all();

        // Reset in the second clear cycle aborts the sweep
        fill_map();
        step(0, AW'(0), '0, '0, 0, 1);
        step(0, AW'(0), '0, '0, 0, 0);
        do_reset();
        step(0, AW'(0), '0, '0, 0, 0);
        query_all();

        for (int n = 0; n < 300; n++) begin
            nb = '0;
            for (int k = 0; k < NB; k++) begin
                nb[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? nb[0 +: AW] : AW'($urandom_range(0, 19));
            end
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 19)), nb,
                 NB'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        for (int d = 0; d < M + 2; d++) step(0, AW'(0), '0, '0, 0, 0);
        chk("sb_drain", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/eda_visited_map.md
EDA_VISITED_MAP -- requirements
Module: eda_visited_map

Interface
REQ-001 SHALL have parameter M, default 16: image rows, ≥2.
REQ-002 SHALL have parameter N, default 16: image columns, ≥2.
REQ-003 SHALL have parameter NUM_NBR, default 8: neighbour address lanes.
REQ-004 SHALL have parameter I_WIDTH, default $clog2(M): row-index width.
REQ-005 SHALL have parameter J_WIDTH, default $clog2(N): column-index width.
REQ-006 SHALL have parameter ADDR_WIDTH, default I_WIDTH+J_WIDTH: pixel address {i,j}, i in upper I_WIDTH bits.
REQ-007 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port clear_req, input, 1: start a map clear sweep.
REQ-010 SHALL have port clear_busy, output, 1: clear sweep in progress.
REQ-011 SHALL have port clear_done, output, 1: one-cycle pulse at sweep end.
REQ-012 SHALL have port new_pixel, input, 1: mark center_addr visited.
REQ-013 SHALL have port center_addr, input, ADDR_WIDTH: centre pixel address.
REQ-014 SHALL have port nbr_addr, input, NUM_NBR*ADDR_WIDTH: lane k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-015 SHALL have port push_positions, input, NUM_NBR: bit k marks nbr lane k visited.
REQ-016 SHALL have port query_valid, input, 1: request flags for centre and all neighbour lanes.
REQ-017 SHALL have port query_ready, output, 1: query accepted when query_valid and query_ready are both high.
REQ-018 SHALL have port rsp_valid, output, 1: response valid, one-cycle pulse.
REQ-019 SHALL have port rsp_flags, output, NUM_NBR+1: bit k = nbr lane k, bit NUM_NBR = centre.
REQ-020 SHALL have port visited_count, output, ADDR_WIDTH+1: number of set flags.

Function
REQ-021 SHALL store M*N one-bit flags, indexed [i][j].
REQ-022 SHALL treat an address with i≥M or j≥N as out of range: writes to it are dropped, and reads of it return 1.
REQ-023 SHALL use a two-state FSM, IDLE and CLEAR; clear_busy=1 exactly in CLEAR.
REQ-024 SHALL move from IDLE to CLEAR on clear_req, with row counter = 0 and visited_count = 0 on the next edge.
REQ-025 SHALL, in CLEAR, zero one full row (N flags) per cycle at the row counter, then increment the counter.
REQ-026 SHALL, on the cycle clearing row M-1, return to IDLE and assert clear_done for the following cycle; a sweep takes exactly M cycles.
REQ-027 SHALL ignore clear_req while in CLEAR (no restart).
REQ-028 SHALL, in CLEAR, ignore new_pixel and push_positions, hold query_ready=0, and produce no rsp_valid.
REQ-029 SHALL, in IDLE, set the flag at center_addr when new_pixel=1, and at lane k when push_positions[k]=1, all on the same edge.
REQ-030 SHALL apply multiple same-cycle writes to one address without conflict (OR semantics).
REQ-031 SHALL drive query_ready = 1 whenever the FSM is IDLE.
REQ-032 SHALL, for an accepted query, assert rsp_valid for exactly one cycle on the next cycle, with registered rsp_flags.
REQ-033 SHALL make query reads write-through: a flag is 1 if stored set, or written by new_pixel/push_positions in the same accepted cycle.
REQ-034 SHALL hold rsp_flags between responses.
REQ-035 SHALL increase visited_count each IDLE cycle by the number of distinct, in-range addresses written that were previously 0. Duplicates and already-set flags SHALL not count.
REQ-036 SHALL keep visited_count ≤ M*N, with no wrap.

Reset
REQ-037 SHALL, while reset=1, immediately set all flags to 0, the FSM to IDLE, and the row counter to 0.
REQ-038 SHALL, while reset=1, immediately set clear_busy, clear_done, rsp_valid, rsp_flags and visited_count to 0; query_ready SHALL be 1 after reset.
REQ-039 SHALL, on reset during CLEAR, abort the sweep with no clear_done pulse; the map SHALL read all-zero after reset.

Verification
REQ-040 SHALL cover (M=N=4): new_pixel, center=6 ({1,2}); next cycle query with center=6 -> rsp_flags[8]=1; visited_count=1.
REQ-041 SHALL cover: push_positions=8'h03 with lanes 0 and 1 both =5, plus new_pixel at 5 -> visited_count +1 only; query of 5 -> 1.
REQ-042 SHALL cover: same-cycle new_pixel at 9 and query with lane 3=9 -> rsp_flags[3]=1 the next cycle (write-through).
REQ-043 SHALL cover: lane 2 address with i=5 at M=4 (ADDR_WIDTH widened) -> rsp_flags[2]=1, no count change.
REQ-044 SHALL cover: map full, clear_req -> clear_busy high 4 cycles, query_ready=0, clear_done pulse, all queries 0, count 0.
REQ-045 SHALL cover: reset asserted in the 2nd CLEAR cycle -> IDLE, no clear_done, all flags and count 0.
